// File: rtl/dma_mc_pkg.sv
// -----------------------------------------------------------------------------
// dma_mc_pkg
// Shared definitions for the multi-channel DMA command front end:
//   - state_e           : command FSM states (IDLE / CALC / ISSUE / ACK)
//   - BOUNDARY_DEFAULT  : default AXI burst-crossing boundary in bytes
//   - ch_width()        : width of a channel index, never less than one bit
//   - min3()            : smallest of three unsigned values (piece sizing)
// -----------------------------------------------------------------------------
package dma_mc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2,
        ACK   = 2'd3
    } state_e;

    localparam int BOUNDARY_DEFAULT = 4096;

    // Wide enough for any address/length width this block is built with;
    // callers cast in and out explicitly.
    typedef logic [63:0] wide_t;

    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic wide_t min3(input wide_t a, input wide_t b, input wide_t c);
        wide_t m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/dma_mc_cmd_arb_rr.sv
// -----------------------------------------------------------------------------
// dma_rr_arbiter
// Combinational round-robin picker: grants the first set bit of req found
// at or after index rr_next, wrapping cyclically.
// Ports:
//   req      in  CH_NUM  request vector
//   rr_next  in  CH_W    highest-priority index for this pick
//   gnt      out CH_NUM  one-hot grant (all zero when req is zero)
//   gnt_idx  out CH_W    binary index of the granted bit (zero when none)
// -----------------------------------------------------------------------------
module dma_rr_arbiter #(
    parameter int CH_NUM = 4,
    parameter int CH_W   = 2
) (
    input  logic [CH_NUM-1:0] req,
    input  logic [CH_W-1:0]   rr_next,
    output logic [CH_NUM-1:0] gnt,
    output logic [CH_W-1:0]   gnt_idx
);

    always_comb begin : pick
        int   j;
        logic found;
        // NOTE: every output gets a default before the loop; a path that
        // leaves an always_comb output unassigned would infer a latch.
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < CH_NUM; k++) begin
            // Modulo keeps a non-power-of-two CH_NUM from indexing past the end.
            j = (int'(rr_next) + k) % CH_NUM;
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = j[CH_W-1:0];
            end
        end
    end

endmodule

// File: rtl/dma_mc_cmd_arb.sv
// -----------------------------------------------------------------------------
// dma_mc_cmd_arb
// Multi-channel command front end for the AXI4 DMA core. Each channel owns a
// ring [base, end) and a write pointer kept here. Requests are granted
// round-robin and split so no command crosses a BOUNDARY-byte line or the
// ring end; the pieces drive the core's addr/length command interface.
// Ports:
//   aclk, reset          clock; synchronous active-high reset
//   ch_base_addr/end_addr per-channel ring bounds (end exclusive), quasi-static
//   ch_req, ch_len       request level and byte length, held until ch_ack
//   ch_clr               pulse: rewind channel pointer to its base
//   ch_ack               one-cycle pulse when a request has been fully issued
//   cmd_valid/ready      command handshake toward the DMA core
//   cmd_addr/len/ch/last command payload (last marks the final piece)
//   busy                 FSM is not idle
// -----------------------------------------------------------------------------
module dma_mc_cmd_arb
    import dma_mc_pkg::*;
#(
    parameter  int CH_NUM         = 4,
    parameter  int AXI_ADDR_WIDTH = 32,
    parameter  int AXI_DATA_WIDTH = 128,
    parameter  int LEN_WIDTH      = 13,
    parameter  int BOUNDARY       = BOUNDARY_DEFAULT,
    localparam int CH_W           = ch_width(CH_NUM)
) (
    input  logic                             aclk,
    input  logic                             reset,
    input  logic [CH_NUM*AXI_ADDR_WIDTH-1:0] ch_base_addr,
    input  logic [CH_NUM*AXI_ADDR_WIDTH-1:0] ch_end_addr,
    input  logic [CH_NUM-1:0]                ch_req,
    input  logic [CH_NUM*LEN_WIDTH-1:0]      ch_len,
    input  logic [CH_NUM-1:0]                ch_clr,
    output logic [CH_NUM-1:0]                ch_ack,
    output logic                             cmd_valid,
    input  logic                             cmd_ready,
    output logic [AXI_ADDR_WIDTH-1:0]        cmd_addr,
    output logic [LEN_WIDTH-1:0]             cmd_len,
    output logic [CH_W-1:0]                  cmd_ch,
    output logic                             cmd_last,
    output logic                             busy
);

    localparam int AW         = AXI_ADDR_WIDTH;
    localparam int AW1        = AXI_ADDR_WIDTH + 1;
    localparam int BEAT_BYTES = AXI_DATA_WIDTH / 8;

    typedef logic [AW-1:0]        addr_t;
    typedef logic [AW1-1:0]       addr1_t;
    typedef logic [LEN_WIDTH-1:0] len_t;
    typedef logic [CH_W-1:0]      ch_t;

    // Addresses are beat aligned; the mask keeps sub-beat bits off the bus.
    localparam addr_t  BEAT_MASK = ~addr_t'(BEAT_BYTES - 1);
    localparam addr1_t BND       = addr1_t'(BOUNDARY);
    localparam addr1_t BND_MASK  = addr1_t'(BOUNDARY - 1);

    // Unpack the flat per-channel buses.
    addr_t base_a [CH_NUM];
    addr_t end_a  [CH_NUM];
    len_t  len_a  [CH_NUM];

    for (genvar g = 0; g < CH_NUM; g++) begin : g_unpack
        assign base_a[g] = ch_base_addr[g*AW +: AW];
        assign end_a[g]  = ch_end_addr[g*AW +: AW];
        assign len_a[g]  = ch_len[g*LEN_WIDTH +: LEN_WIDTH];
    end

    state_e              state_q, state_d;
    ch_t                 ch_q, ch_d;
    ch_t                 rr_next_q, rr_next_d;
    len_t                rem_q, rem_d;
    addr_t               p_q, p_d;
    logic                clr_pend_q, clr_pend_d;
    addr_t               ptr_q [CH_NUM];
    addr_t               ptr_d [CH_NUM];
    logic                cmd_valid_q, cmd_valid_d;
    addr_t               cmd_addr_q, cmd_addr_d;
    len_t                cmd_len_q, cmd_len_d;
    ch_t                 cmd_ch_q, cmd_ch_d;
    logic                cmd_last_q, cmd_last_d;
    logic [CH_NUM-1:0]   ch_ack_q, ch_ack_d;

    // Round-robin grant.
    logic [CH_NUM-1:0]   gnt_oh;
    ch_t                 gnt_idx;

    dma_rr_arbiter #(
        .CH_NUM (CH_NUM),
        .CH_W   (CH_W)
    ) u_arb (
        .req     (ch_req),
        .rr_next (rr_next_q),
        .gnt     (gnt_oh),
        .gnt_idx (gnt_idx)
    );

    // One-hot select of the granted channel's pointer, length and clear.
    addr_t sel_ptr;
    len_t  sel_len;
    logic  sel_clr;

    always_comb begin
        sel_ptr = '0;
        sel_len = '0;
        sel_clr = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (gnt_oh[i]) begin
                sel_ptr = sel_ptr | ptr_q[i];
                sel_len = sel_len | len_a[i];
                sel_clr = sel_clr | ch_clr[i];
            end
        end
    end

    // Piece sizing, one bit wider than the address so end - p and the
    // distance to the next boundary cannot overflow.
    addr1_t p_ext, end_ext, to_bnd, to_end, piece, p_sum;

    always_comb begin
        p_ext   = addr1_t'(p_q);
        end_ext = addr1_t'(end_a[ch_q]);
        to_bnd  = BND - (p_ext & BND_MASK);
        to_end  = end_ext - p_ext;
        piece   = addr1_t'(min3(wide_t'(rem_q), wide_t'(to_bnd), wide_t'(to_end)));
        p_sum   = p_ext + addr1_t'(cmd_len_q);
    end

    // Next-state and datapath.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        rr_next_d   = rr_next_q;
        rem_d       = rem_q;
        p_d         = p_q;
        clr_pend_d  = clr_pend_q;
        ptr_d       = ptr_q;
        cmd_valid_d = cmd_valid_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_len_d   = cmd_len_q;
        cmd_ch_d    = cmd_ch_q;
        cmd_last_d  = cmd_last_q;
        ch_ack_d    = '0;

        // Clears on channels not currently being served take effect at once.
        for (int i = 0; i < CH_NUM; i++) begin
            if (ch_clr[i] && !(state_q != IDLE && int'(ch_q) == i)) begin
                ptr_d[i] = base_a[i];
            end
        end

        // A clear on the served channel is deferred to its ACK so the
        // request in flight finishes at the old pointer.
        if (state_q != IDLE && ch_clr[ch_q]) begin
            clr_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (|gnt_oh) begin
                    ch_d       = gnt_idx;
                    rem_d      = sel_len;
                    p_d        = sel_clr ? base_a[gnt_idx] : sel_ptr;
                    clr_pend_d = 1'b0;
                    if (sel_len == '0) begin
                        // Nothing to move: acknowledge without a command.
                        state_d  = ACK;
                        ch_ack_d = gnt_oh;
                    end else begin
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                cmd_valid_d = 1'b1;
                cmd_addr_d  = p_q & BEAT_MASK;
                cmd_len_d   = len_t'(piece);
                cmd_ch_d    = ch_q;
                cmd_last_d  = (piece == addr1_t'(rem_q));
                state_d     = ISSUE;
            end

            ISSUE: begin
                if (cmd_valid_q && cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    p_d         = (p_sum == end_ext) ? base_a[ch_q] : addr_t'(p_sum);
                    rem_d       = rem_q - cmd_len_q;
                    if (cmd_last_q) begin
                        state_d        = ACK;
                        ch_ack_d[ch_q] = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end

            ACK: begin
                ptr_d[ch_q] = (clr_pend_q || ch_clr[ch_q]) ? base_a[ch_q] : p_q;
                rr_next_d   = (int'(ch_q) == CH_NUM - 1) ? '0 : ch_q + 1'b1;
                clr_pend_d  = 1'b0;
                state_d     = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        // NOTE: state registers use non-blocking assignments only, so every
        // flop samples its _d value from before this edge regardless of order.
        if (reset) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            rr_next_q   <= '0;
            rem_q       <= '0;
            p_q         <= '0;
            clr_pend_q  <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
            cmd_ch_q    <= '0;
            cmd_last_q  <= 1'b0;
            ch_ack_q    <= '0;
            // NOTE: the pointer array is reset on purpose -- each ring must
            // restart at its base -- so it is built from flops, not RAM.
            for (int i = 0; i < CH_NUM; i++) begin
                ptr_q[i] <= base_a[i];
            end
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            rr_next_q   <= rr_next_d;
            rem_q       <= rem_d;
            p_q         <= p_d;
            clr_pend_q  <= clr_pend_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_len_q   <= cmd_len_d;
            cmd_ch_q    <= cmd_ch_d;
            cmd_last_q  <= cmd_last_d;
            ch_ack_q    <= ch_ack_d;
            ptr_q       <= ptr_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_len   = cmd_len_q;
    assign cmd_ch    = cmd_ch_q;
    assign cmd_last  = cmd_last_q;
    assign ch_ack    = ch_ack_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dma_mc_cmd_arb.sv
// -----------------------------------------------------------------------------
// tb_dma_mc_cmd_arb
// Directed bench for dma_mc_cmd_arb with four channels:
//   ch0 ring [0x0000, 0x14000)    ch1 ring [0x0F00, 0x14000)
//   ch2 ring [0x0000, 0x14000) (pointer preset to 0x13F80 through reset)
//   ch3 ring [0x2000, 0x2100)     (small ring for oversize requests)
// Inputs change 1 time unit after the rising edge; outputs are read there.
// -----------------------------------------------------------------------------
module tb_dma_mc_cmd_arb;

    localparam int CH_NUM = 4;
    localparam int AW     = 32;
    localparam int LW     = 13;
    localparam int CH_W   = 2;

    logic                   aclk;
    logic                   reset;
    logic [CH_NUM*AW-1:0]   ch_base_addr;
    logic [CH_NUM*AW-1:0]   ch_end_addr;
    logic [CH_NUM-1:0]      ch_req;
    logic [CH_NUM*LW-1:0]   ch_len;
    logic [CH_NUM-1:0]      ch_clr;
    logic [CH_NUM-1:0]      ch_ack;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [AW-1:0]          cmd_addr;
    logic [LW-1:0]          cmd_len;
    logic [CH_W-1:0]        cmd_ch;
    logic                   cmd_last;
    logic                   busy;

    int n_checks = 0;
    int n_errors = 0;

    dma_mc_cmd_arb #(
        .CH_NUM         (CH_NUM),
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (128),
        .LEN_WIDTH      (LW),
        .BOUNDARY       (4096)
    ) dut (
        .aclk         (aclk),
        .reset        (reset),
        .ch_base_addr (ch_base_addr),
        .ch_end_addr  (ch_end_addr),
        .ch_req       (ch_req),
        .ch_len       (ch_len),
        .ch_clr       (ch_clr),
        .ch_ack       (ch_ack),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .cmd_ch       (cmd_ch),
        .cmd_last     (cmd_last),
        .busy         (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int ch, input logic [LW-1:0] len);
        ch_len[ch*LW +: LW] = len;
        ch_req[ch]          = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        int cyc = 0;
        while (!cmd_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, ".valid"}, 64'(cmd_valid), 64'h1);
    endtask

    task automatic check_cmd(input string tag, input logic [AW-1:0] a, input logic [LW-1:0] l,
                             input logic [CH_W-1:0] c, input logic last);
        check({tag, ".addr"}, 64'(cmd_addr), 64'(a));
        check({tag, ".len"},  64'(cmd_len),  64'(l));
        check({tag, ".ch"},   64'(cmd_ch),   64'(c));
        check({tag, ".last"}, 64'(cmd_last), 64'(last));
    endtask

    // Waits for the next command, checks it, and lets it handshake (cmd_ready high).
    task automatic expect_cmd(input string tag, input logic [AW-1:0] a, input logic [LW-1:0] l,
                              input logic [CH_W-1:0] c, input logic last);
        wait_valid(tag);
        check_cmd(tag, a, l, c, last);
        tick();
    endtask

    // Waits for ch_ack, checks it is for channel ch, and drops that request.
    task automatic wait_ack(input string tag, input int ch);
        int cyc = 0;
        logic [CH_NUM-1:0] exp_ack;
        exp_ack     = '0;
        exp_ack[ch] = 1'b1;
        while (ch_ack == '0 && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, ".ack"}, 64'(ch_ack), 64'(exp_ack));
        ch_req[ch] = 1'b0;
        tick();
    endtask

    initial begin
        reset        = 1'b1;
        cmd_ready    = 1'b1;
        ch_req       = '0;
        ch_clr       = '0;
        ch_len       = '0;
        ch_base_addr = '0;
        ch_end_addr  = '0;
        ch_base_addr[0*AW +: AW] = 32'h0000_0000;  ch_end_addr[0*AW +: AW] = 32'h0001_4000;
        ch_base_addr[1*AW +: AW] = 32'h0000_0F00;  ch_end_addr[1*AW +: AW] = 32'h0001_4000;
        ch_base_addr[2*AW +: AW] = 32'h0001_3F80;  ch_end_addr[2*AW +: AW] = 32'h0001_4000;
        ch_base_addr[3*AW +: AW] = 32'h0000_2000;  ch_end_addr[3*AW +: AW] = 32'h0000_2100;
        tick(); tick(); tick();

        // Reset values.
        check("rst.valid", 64'(cmd_valid), 64'h0);
        check("rst.addr",  64'(cmd_addr),  64'h0);
        check("rst.len",   64'(cmd_len),   64'h0);
        check("rst.ch",    64'(cmd_ch),    64'h0);
        check("rst.last",  64'(cmd_last),  64'h0);
        check("rst.ack",   64'(ch_ack),    64'h0);
        check("rst.busy",  64'(busy),      64'h0);

        reset = 1'b0;
        // ch2 pointer stays at 0x13F80; its ring now starts at 0.
        ch_base_addr[2*AW +: AW] = 32'h0000_0000;
        tick();

        // Single channel, exact latency: valid two cycles after req is sampled.
        set_req(0, 13'h200);
        tick();
        check("t1.n1.valid", 64'(cmd_valid), 64'h0);
        check("t1.n1.busy",  64'(busy),      64'h1);
        tick();
        check("t1.n2.valid", 64'(cmd_valid), 64'h1);
        check_cmd("t1.cmd", 32'h0, 13'h200, 2'd0, 1'b1);
        tick();
        check("t1.hs.valid", 64'(cmd_valid), 64'h0);
        check("t1.hs.ack",   64'(ch_ack),    64'h1);
        ch_req[0] = 1'b0;
        tick();
        check("t1.idle.ack",  64'(ch_ack), 64'h0);
        check("t1.idle.busy", 64'(busy),   64'h0);

        // ptr[0] advanced to 0x200.
        set_req(0, 13'h100);
        expect_cmd("t1b", 32'h200, 13'h100, 2'd0, 1'b1);
        wait_ack("t1b", 0);

        // 4 KB split on ch1, no ack between the pieces.
        set_req(1, 13'h200);
        expect_cmd("t2.p0", 32'h0F00, 13'h100, 2'd1, 1'b0);
        check("t2.mid.ack", 64'(ch_ack), 64'h0);
        expect_cmd("t2.p1", 32'h1000, 13'h100, 2'd1, 1'b1);
        wait_ack("t2", 1);

        // Ring-end wrap on ch2.
        set_req(2, 13'h100);
        expect_cmd("t3.p0", 32'h1_3F80, 13'h080, 2'd2, 1'b0);
        expect_cmd("t3.p1", 32'h0,      13'h080, 2'd2, 1'b1);
        wait_ack("t3", 2);

        // Request larger than the whole ch3 ring (0x100 bytes).
        set_req(3, 13'h200);
        expect_cmd("t4.p0", 32'h2000, 13'h100, 2'd3, 1'b0);
        expect_cmd("t4.p1", 32'h2000, 13'h100, 2'd3, 1'b1);
        wait_ack("t4", 3);

        // Round robin: all four together, rr_next back at 0.
        set_req(0, 13'h010);
        set_req(1, 13'h010);
        set_req(2, 13'h040);
        set_req(3, 13'h010);
        expect_cmd("t5.c0", 32'h0300, 13'h010, 2'd0, 1'b1);
        wait_ack("t5.c0", 0);
        expect_cmd("t5.c1", 32'h1100, 13'h010, 2'd1, 1'b1);
        wait_ack("t5.c1", 1);
        expect_cmd("t5.c2", 32'h0080, 13'h040, 2'd2, 1'b1);
        wait_ack("t5.c2", 2);
        expect_cmd("t5.c3", 32'h2000, 13'h010, 2'd3, 1'b1);
        wait_ack("t5.c3", 3);

        // ch1 and ch3 re-request with rr_next=0 -> 1 then 3.
        set_req(3, 13'h020);
        set_req(1, 13'h020);
        expect_cmd("t5.r1", 32'h1110, 13'h020, 2'd1, 1'b1);
        wait_ack("t5.r1", 1);
        expect_cmd("t5.r3", 32'h2010, 13'h020, 2'd3, 1'b1);
        wait_ack("t5.r3", 3);

        // Zero-length request: ack without any command.
        set_req(0, 13'h000);
        tick();
        check("t6.ack",   64'(ch_ack),    64'h1);
        check("t6.valid", 64'(cmd_valid), 64'h0);
        ch_req[0] = 1'b0;
        tick();
        check("t6.idle.busy", 64'(busy), 64'h0);

        // Backpressure with a clear on the active channel.
        cmd_ready = 1'b0;
        set_req(0, 13'h200);
        wait_valid("t7");
        check_cmd("t7.start", 32'h0310, 13'h200, 2'd0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            ch_clr[0] = (k == 2);
            tick();
            check("t7.hold.valid", 64'(cmd_valid), 64'h1);
            check_cmd("t7.hold", 32'h0310, 13'h200, 2'd0, 1'b1);
        end
        ch_clr    = '0;
        cmd_ready = 1'b1;
        tick();
        wait_ack("t7", 0);
        set_req(0, 13'h010);
        expect_cmd("t7.clr", 32'h0, 13'h010, 2'd0, 1'b1);
        wait_ack("t7.clr", 0);

        // Clear on an idle channel.
        ch_clr[1] = 1'b1;
        tick();
        ch_clr[1] = 1'b0;
        set_req(1, 13'h010);
        expect_cmd("t7.iclr", 32'h0F00, 13'h010, 2'd1, 1'b1);
        wait_ack("t7.iclr", 1);

        // Reset while a command is waiting in ISSUE.
        cmd_ready = 1'b0;
        set_req(2, 13'h040);
        wait_valid("t8");
        check_cmd("t8.pre", 32'h00C0, 13'h040, 2'd2, 1'b1);
        ch_req = '0;
        reset  = 1'b1;
        tick();
        check("t8.valid", 64'(cmd_valid), 64'h0);
        check("t8.busy",  64'(busy),      64'h0);
        check("t8.ack",   64'(ch_ack),    64'h0);
        reset     = 1'b0;
        cmd_ready = 1'b1;
        tick();
        check("t8.post.ack", 64'(ch_ack), 64'h0);

        // Every pointer is back at its base, rr_next at 0.
        set_req(0, 13'h010);
        set_req(1, 13'h010);
        set_req(2, 13'h010);
        set_req(3, 13'h010);
        expect_cmd("t8.c0", 32'h0000, 13'h010, 2'd0, 1'b1);
        wait_ack("t8.c0", 0);
        expect_cmd("t8.c1", 32'h0F00, 13'h010, 2'd1, 1'b1);
        wait_ack("t8.c1", 1);
        expect_cmd("t8.c2", 32'h0000, 13'h010, 2'd2, 1'b1);
        wait_ack("t8.c2", 2);
        expect_cmd("t8.c3", 32'h2000, 13'h010, 2'd3, 1'b1);
        wait_ack("t8.c3", 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
